// File: rtl/game_sequencer_if.sv
// rtl/game_sequencer_if.sv - tick handshake between the game sequencer, snake engine and apple placer
interface game_sequencer_if;
   logic o_tick;
   logic i_tick_done;
   logic i_apple_ready;

   modport master (output o_tick, input i_tick_done, input i_apple_ready);
   modport slave  (input o_tick, output i_tick_done, output i_apple_ready);
endinterface

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - game phase controller gating frames into snake ticks (optional GAME_TICK_WATCHDOG_EN)
module game_sequencer #(
   parameter int unsigned FRAMES_MAX  = 16,
   parameter int unsigned FRAMES_STEP = 2,
   parameter int unsigned WDT_CYCLES  = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_restart,
   input  logic              i_start,
   input  logic              i_pause,
   input  logic              i_frame,
   input  logic              i_speed_up,
   input  logic              i_speed_down,
   input  logic              i_failure,
   input  logic              i_success,
   game_sequencer_if.master  eng,
   output logic [2:0]        o_phase,
   output logic [2:0]        o_speed,
   output logic              o_failure,
   output logic              o_success,
   output logic              o_wdt
);
   localparam int CW = $clog2(FRAMES_MAX + 1);

   if ((FRAMES_MAX <= 7 * FRAMES_STEP) || (WDT_CYCLES < 1) || (WDT_CYCLES > 256)) begin : g_cfg_check
      $error("game_sequencer: FRAMES_MAX must exceed 7*FRAMES_STEP and WDT_CYCLES must be 1..256");
   end

   typedef enum logic [2:0] {
      S_IDLE = 3'd0, S_RUN = 3'd1, S_WAIT = 3'd2, S_PAUSE = 3'd3, S_FAIL = 3'd4, S_WIN = 3'd5
   } state_e;

   state_e          state_q, state_d;
   logic [2:0]      speed_q, speed_d;
   logic [CW-1:0]   frame_cnt_q, frame_cnt_d;
   logic            due_q, due_d;
   logic            pause_prev_q;
   logic            pause_pend_q, pause_pend_d;
   logic            tick_q;
   logic            pause_edge, pend_now, issue, wdt_expired, wdt_flag;
   logic            count_en, expire;
   logic [31:0]     cnt_inc, interval;

   assign pause_edge = i_pause & ~pause_prev_q;
   assign pend_now   = pause_pend_q | pause_edge;

`ifdef GAME_TICK_WATCHDOG_EN
   localparam logic [7:0] WDT_LIMIT = 8'(WDT_CYCLES - 1);
   logic [7:0] wdt_cnt_q;
   logic       wdt_q;

   assign wdt_expired = (state_q == S_WAIT) && (wdt_cnt_q == WDT_LIMIT) && !eng.i_tick_done;
   assign wdt_flag    = wdt_q;

   // watchdog: count cycles spent in WAIT, flag a tick that never completed
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wdt_cnt_q <= 8'd0;
         wdt_q     <= 1'b0;
      end else begin
         wdt_cnt_q <= (state_q == S_WAIT && state_d == S_WAIT) ? wdt_cnt_q + 8'd1 : 8'd0;
         if (i_restart)
            wdt_q <= 1'b0;
         else if (wdt_expired && state_d != S_FAIL && state_d != S_WIN)
            wdt_q <= 1'b1;
      end
   end
`else
   assign wdt_expired = 1'b0;
   assign wdt_flag    = 1'b0;
`endif

   // state register plus speed, frame counter, due flag and pause tracking
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         speed_q      <= 3'd0;
         frame_cnt_q  <= '0;
         due_q        <= 1'b0;
         pause_pend_q <= 1'b0;
         tick_q       <= 1'b0;
         // a held button must not toggle pause once reset releases
         pause_prev_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         speed_q      <= speed_d;
         frame_cnt_q  <= frame_cnt_d;
         due_q        <= due_d;
         pause_pend_q <= pause_pend_d;
         tick_q       <= issue;
         pause_prev_q <= i_pause;
      end
   end

   // next state: restart > failure > success > normal phase flow
   always_comb begin
      state_d = state_q;
      issue   = 1'b0;
      if (i_restart) begin
         state_d = S_IDLE;
      end else if (i_failure && state_q inside {S_RUN, S_WAIT, S_PAUSE}) begin
         state_d = S_FAIL;
      end else if (i_success && state_q inside {S_RUN, S_WAIT, S_PAUSE}) begin
         state_d = S_WIN;
      end else begin
         case (state_q)
            S_IDLE:  if (i_start) state_d = S_RUN;
            S_RUN: begin
               if (due_q && eng.i_apple_ready) begin
                  state_d = S_WAIT;
                  issue   = 1'b1;
               end else if (pause_edge) begin
                  state_d = S_PAUSE;
               end
            end
            S_WAIT:  if (eng.i_tick_done || wdt_expired) state_d = pend_now ? S_PAUSE : S_RUN;
            S_PAUSE: if (pause_edge) state_d = S_RUN;
            default: state_d = state_q;
         endcase
      end
   end

   // speed, frame interval bookkeeping and the deferred pause request
   always_comb begin
      speed_d = speed_q;
      case ({i_speed_up, i_speed_down})
         2'b10:   if (speed_q != 3'd7) speed_d = speed_q + 3'd1;
         2'b01:   if (speed_q != 3'd0) speed_d = speed_q - 3'd1;
         default: speed_d = speed_q;
      endcase

      interval = FRAMES_MAX - ({29'd0, speed_q} * FRAMES_STEP);
      cnt_inc  = {{(32-CW){1'b0}}, frame_cnt_q} + 32'd1;
      count_en = i_frame && (state_q == S_RUN || state_q == S_WAIT);
      expire   = count_en && (cnt_inc >= interval);

      frame_cnt_d  = frame_cnt_q;
      due_d        = (due_q & ~issue) | expire;
      pause_pend_d = pause_pend_q;
      if (i_restart) begin
         frame_cnt_d  = '0;
         due_d        = 1'b0;
         pause_pend_d = 1'b0;
      end else begin
         if (expire)
            frame_cnt_d = '0;
         else if (count_en)
            frame_cnt_d = cnt_inc[CW-1:0];
         if (state_q == S_WAIT && state_d != S_WAIT)
            pause_pend_d = 1'b0;
         else if (pause_edge && (issue || state_q == S_WAIT))
            pause_pend_d = 1'b1;
      end
   end

   // outputs are direct views of registered state
   always_comb begin
      o_phase    = state_q;
      o_speed    = speed_q;
      o_failure  = (state_q == S_FAIL);
      o_success  = (state_q == S_WIN);
      o_wdt      = wdt_flag;
      eng.o_tick = tick_q;
   end
endmodule
